// File: rtl/level0_shift_lock.sv
// level0_shift_lock: serial combination lock.
//   Bits on d are clocked into a WIDTH-bit shift register on each rising edge
//   of the slow, asynchronous shift strobe (MSB of the key first). led1 shows a
//   live match of the register against KEY; led2 latches once a match occurs.
// Ports:
//   clk    in   system clock, all state on rising edge
//   rst    in   synchronous active-high reset (priority over a shift edge)
//   shift  in   asynchronous shift strobe, one bit per rising edge
//   d      in   asynchronous serial data, captured with the shift edge
//   led1   out  registered live match
//   led2   out  registered sticky match
// Build option: define LEVEL0_DEBOUNCE_EN to debounce the synchronised shift
//   strobe for DEB_CYCLES clk before its edge is accepted.
module level0_shift_lock #(
   parameter int unsigned     WIDTH       = 16,
   parameter logic [WIDTH-1:0] KEY        = 16'h39C3,
   parameter int unsigned     SYNC_STAGES = 2,
   parameter int unsigned     DEB_CYCLES  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic shift,
   input  logic d,
   output logic led1,
   output logic led2
);

   localparam int unsigned FW = $clog2(WIDTH + 1);

   logic [SYNC_STAGES-1:0] shift_sync;
   logic [SYNC_STAGES-1:0] d_sync;
   logic                   sync_shift;
   logic                   sync_d;
   logic                   acc_level;
   logic                   acc_level_q;
   logic                   shift_edge;
   logic [WIDTH-1:0]       sr;
   logic [FW-1:0]          fill;
   logic                   match;

   // Equal-depth synchronisers keep d aligned with shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_sync <= '0;
         d_sync     <= '0;
      end else begin
         shift_sync[0] <= shift;
         d_sync[0]     <= d;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            shift_sync[i] <= shift_sync[i-1];
            d_sync[i]     <= d_sync[i-1];
         end
      end
   end

   assign sync_shift = shift_sync[SYNC_STAGES-1];
   assign sync_d     = d_sync[SYNC_STAGES-1];

`ifdef LEVEL0_DEBOUNCE_EN
   localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic          deb_level;
   logic [DW-1:0] deb_cnt;

   // Accept a new shift level only after it has differed for DEB_CYCLES clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         deb_level <= 1'b0;
         deb_cnt   <= '0;
      end else if (sync_shift != deb_level) begin
         if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            deb_level <= sync_shift;
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end else begin
         deb_cnt <= '0;
      end
   end

   assign acc_level = deb_level;
`else
   assign acc_level = sync_shift;

   // DEB_CYCLES only shapes the debounce build.
   if (DEB_CYCLES == 0) begin : g_deb_unused
   end
`endif

   // Rising-edge detect on the accepted shift level.
   always_ff @(posedge clk) begin
      if (rst) acc_level_q <= 1'b0;
      else     acc_level_q <= acc_level;
   end

   assign shift_edge = acc_level & ~acc_level_q;

   // Shift register and saturating fill count.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr   <= '0;
         fill <= '0;
      end else if (shift_edge) begin
         sr <= {sr[WIDTH-2:0], sync_d};
         if (fill != FW'(WIDTH)) fill <= fill + FW'(1);
      end
   end

   // A match needs a full register so an all-zero KEY cannot match at reset.
   assign match = (fill == FW'(WIDTH)) && (sr == KEY);

   always_ff @(posedge clk) begin
      if (rst) begin
         led1 <= 1'b0;
         led2 <= 1'b0;
      end else begin
         led1 <= match;
         led2 <= led2 | match;
      end
   end

endmodule

// File: tb/tb_level0_shift_lock.sv
module tb_level0_shift_lock;

   localparam logic [15:0] KEY = 16'h39C3;
`ifdef LEVEL0_DEBOUNCE_EN
   localparam int LAT = 8;
`else
   localparam int LAT = 4;
`endif
   localparam int HI = 8;
   localparam int LO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic shift = 1'b0;
   logic d = 1'b0;
   logic led1, led2;

   int checks = 0;
   int errors = 0;

   typedef struct { logic l1; logic l2; } exp_t;
   typedef struct { logic d; logic e1; logic e2; } vec_t;

   exp_t sb[$];
   vec_t vec[16];

   logic [15:0] m_sr;
   int          m_fill;
   logic        m_led2;

   level0_shift_lock dut (
      .clk   (clk),
      .rst   (rst),
      .shift (shift),
      .d     (d),
      .led1  (led1),
      .led2  (led2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic model_step(input logic b);
      m_sr = {m_sr[14:0], b};
      if (m_fill < 16) m_fill++;
      model_step = (m_fill == 16) && (m_sr == KEY);
      m_led2 = m_led2 | model_step;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; shift = 1'b0; d = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      m_sr = '0; m_fill = 0; m_led2 = 1'b0;
      @(negedge clk);
      chk("reset_led1", 32'(led1), 32'd0);
      chk("reset_led2", 32'(led2), 32'd0);
      chk("reset_fill", 32'(dut.fill), 32'd0);
      chk("reset_sr", 32'(dut.sr), 32'd0);
   endtask

   // One shift pulse with expected LEDs queued at drive time, compared after settling.
   task automatic drive(input logic b, input logic e1, input logic e2, input string name);
      exp_t e;
      e.l1 = e1; e.l2 = e2;
      sb.push_back(e);
      @(posedge clk); #1;
      d = b; shift = 1'b1;
      repeat (HI) @(posedge clk);
      #1 shift = 1'b0;
      repeat (LO) @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         chk({name, "_led1"}, 32'(led1), 32'(e.l1));
         chk({name, "_led2"}, 32'(led2), 32'(e.l2));
      end
   endtask

   task automatic mpulse(input logic b, input string name);
      logic m;
      m = model_step(b);
      drive(b, m, m_led2, name);
   endtask

   task automatic mword(input logic [15:0] w, input int n, input string name);
      for (int i = 15; i > 15 - n; i--) mpulse(w[i], name);
   endtask

   initial begin
      logic m;
      logic [4:0] junk;
      junk = 5'b11011;
      m_sr = '0; m_fill = 0; m_led2 = 1'b0;

      for (int i = 0; i < 16; i++) begin
         vec[i].d  = KEY[15-i];
         vec[i].e1 = (i == 15);
         vec[i].e2 = (i == 15);
      end

      // 1: key entry from table
      do_reset();
      for (int i = 0; i < 16; i++) begin
         m = model_step(vec[i].d);
         drive(vec[i].d, vec[i].e1, vec[i].e2, "key");
      end
      chk("t1_fill", 32'(dut.fill), 32'd16);

      // 2: overshift
      for (int i = 0; i < 3; i++) mpulse(1'b1, "over");
      chk("t2_sr", 32'(dut.sr), 32'hCE1F);
      chk("t2_led1", 32'(led1), 32'd0);
      chk("t2_led2", 32'(led2), 32'd1);

      // 3: near-miss key, then one more bit each way
      do_reset();
      mword(16'h39C2, 16, "near");
      mpulse(1'b0, "near0");
      chk("t3_sr0", 32'(dut.sr), 32'h7384);
      do_reset();
      mword(16'h39C2, 16, "near");
      mpulse(1'b1, "near1");
      chk("t3_sr1", 32'(dut.sr), 32'h7385);
      chk("t3_led2", 32'(led2), 32'd0);

      // 4: junk then key, exact latency on the final bit
      do_reset();
      for (int i = 4; i >= 0; i--) mpulse(junk[i], "junk");
      mword(KEY, 15, "k15");
      @(posedge clk); #1;
      d = KEY[0]; shift = 1'b1;
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk);
      chk("t4_lat_before", 32'(led1), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("t4_lat_at", 32'(led1), 32'd1);
      chk("t4_led2_at", 32'(led2), 32'd1);
      #1 shift = 1'b0;
      repeat (LO) @(posedge clk);
      m = model_step(KEY[0]);
      mpulse(1'b0, "after");
      chk("t4_drop", 32'(led1), 32'd0);

      // 5: reset mid-key
      do_reset();
      mword(KEY, 8, "half");
      do_reset();
      for (int i = 7; i >= 0; i--) mpulse(KEY[i], "tail");
      chk("t5_fill", 32'(dut.fill), 32'd8);
      chk("t5_led1", 32'(led1), 32'd0);
      mword(KEY, 16, "rekey");
      chk("t5_rekey", 32'(led1), 32'd1);

      // 6: long hold gives one shift
      do_reset();
      @(posedge clk); #1;
      d = 1'b1; shift = 1'b1;
      repeat (50) @(posedge clk);
      #1 shift = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("t6_fill", 32'(dut.fill), 32'd1);
      chk("t6_sr", 32'(dut.sr), 32'd1);

`ifdef LEVEL0_DEBOUNCE_EN
      // 1-clk glitch is rejected
      @(posedge clk); #1;
      shift = 1'b1;
      @(posedge clk); #1;
      shift = 1'b0;
      repeat (16) @(posedge clk);
      @(negedge clk);
      chk("t6_glitch", 32'(dut.fill), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
